dbg_reg_scanner: RTL and testbench
==================================

Name: dbg_reg_scanner

Overview:
Debug-side reader for the dcpu register-file debug read port (raddr -> odata). On a start pulse it walks raddr over every architectural register, waits for odata to settle, captures each word, and streams it out over a valid/ready handshake. It also accumulates an XOR checksum. It sits beside dcpu_top in FPGA and bench builds, replacing hand-driven raddr probing for post-run register dumps.

Parameters:
NREG, 32, number of registers scanned (indices 0..NREG-1); legal range 1..32.
DW, 32, data width of odata and out_data.
SETTLE, 1, cycles held between a raddr change and odata capture; legal range 0..15.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  1-cycle scan request; honoured only in IDLE
abort  in  1  synchronous scan cancel
raddr  out  5  debug register address to dcpu_top
odata  in  DW  debug read data from dcpu_top
out_data  out  DW  captured register word
out_idx  out  6  index of the word on out_data
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  consumer accepts the word
busy  out  1  high from start acceptance until DONE
done  out  1  1-cycle pulse when the scan completes
chksum  out  DW  XOR of all words emitted in the last or current scan

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, raddr=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, chksum=0, idx=0.
- States: IDLE, ADDR, WAIT, CAP, OUT, DONE.
- IDLE: on start=1, idx<=0, chksum<=0, busy<=1, go to ADDR. start in any other state is ignored.
- ADDR (1 cycle): raddr<=idx[4:0], settle counter<=SETTLE. Go to WAIT if SETTLE>0, otherwise CAP.
- WAIT: decrement the counter. At 1, go to CAP. Total hold from raddr update to capture is SETTLE+1 edges.
- CAP (1 cycle): out_data<=odata, out_idx<=idx, out_valid<=1, chksum<=chksum^odata. Go to OUT.
- OUT: hold out_data, out_idx and out_valid stable until out_ready=1. A transfer is the cycle where out_valid&&out_ready=1.
  - On transfer with idx==NREG-1: out_valid<=0, go to DONE.
  - On any other transfer: idx<=idx+1, out_valid<=0, go to ADDR.
  - With out_ready held high, throughput is one word per SETTLE+3 cycles.
- DONE (1 cycle): done=1, busy<=0, go to IDLE. chksum holds its value until the next accepted start.
- abort=1 in any non-IDLE state: next edge goes to IDLE with out_valid=0, busy=0, no done pulse. chksum keeps its partial value. abort has priority over transfer in the same cycle, and that word counts as not transferred. abort in IDLE has no effect.
- raddr is driven only from the raddr register, never combinationally.
- The snapshot is not atomic. The CPU keeps running, and each word reflects the register at its own CAP cycle.
- rst asserted mid-scan: immediate return to reset values. No done pulse, no partial word.

Optional Feature:
- Macro: DBG_SCAN_PERF_EN.
- Defined:
  - Adds a free-running cycle counter (DW bits, wrapping).
  - Adds a NOP counter (DW bits) that increments each cycle where added input instr[31:0]==0.
  - Both counters reset to 0.
  - Two extra words follow register NREG-1: out_idx=NREG holds the cycle count and out_idx=NREG+1 holds the NOP count. Each is sampled in its own CAP cycle, skips ADDR/WAIT, and is included in chksum.
  - DONE follows the transfer of index NREG+1.
- Undefined: no instr port, no counters, scan ends after NREG-1.

Test Plan:
- Registers r_i = 0x1000_0000+i, out_ready=1, SETTLE=1, start pulse -> 32 words, out_idx 0..31, out_data 0x1000_0000..0x1000_001F, one transfer per 4 cycles. done pulses once, busy drops with done, and chksum = XOR of all 32 values.
- Same as above, but out_ready toggles 1-0-0-1 during OUT -> out_data/out_idx stay stable while stalled, no word is lost or duplicated, and the sequence still ends at idx 31.
- abort asserted while out_idx=5 and out_valid=1 -> next cycle IDLE, out_valid=0, busy=0, no done. A new start restarts from out_idx=0 with chksum reset.
- rst pulled low during WAIT of idx 10 -> all outputs 0 asynchronously. After release, IDLE; start gives a full scan.
- start pulsed again at idx 3 -> ignored, and the scan completes normally with exactly 32 words.
- DBG_SCAN_PERF_EN defined, bench forces instr=0 for 7 cycles -> words 32 and 33 are emitted, with word 33 = 7 and word 32 = the cycle count at its CAP. done pulses after word 33.

Source files
------------

// File: rtl/dbg_reg_scanner.sv
// Debug register-file scanner: walks raddr over NREG registers, captures odata and streams words out.
// Optional DBG_SCAN_PERF_EN appends a cycle-count word and a NOP-count word to every scan.
module dbg_reg_scanner #(
   parameter int NREG   = 32,
   parameter int DW     = 32,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic [4:0]    raddr,
   input  logic [DW-1:0] odata,
   output logic [DW-1:0] out_data,
   output logic [5:0]    out_idx,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] chksum
`ifdef DBG_SCAN_PERF_EN
   ,
   input  logic [31:0]   instr
`endif
);

`ifdef DBG_SCAN_PERF_EN
   localparam int NWORDS = NREG + 2;
`else
   localparam int NWORDS = NREG;
`endif
   localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);
   localparam logic [5:0] REG_LAST = 6'(NREG - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      CAP  = 3'd3,
      OUT  = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t        state_r;
   state_t        next_s;
   logic [5:0]    idx_r;
   logic [3:0]    cnt_r;
   logic [4:0]    raddr_r;
   logic [DW-1:0] out_data_r;
   logic [5:0]    out_idx_r;
   logic          out_valid_r;
   logic          busy_r;
   logic          done_r;
   logic [DW-1:0] chksum_r;
   logic          xfer_s;
   logic          kill_s;
   logic [DW-1:0] cap_word_s;

   assign xfer_s = out_valid_r & out_ready;
   assign kill_s = abort & (state_r != IDLE);

`ifdef DBG_SCAN_PERF_EN
   logic [DW-1:0] cyc_r;
   logic [DW-1:0] nop_r;

   // Free-running cycle counter and NOP counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_r <= '0;
         nop_r <= '0;
      end else begin
         cyc_r <= cyc_r + {{(DW-1){1'b0}}, 1'b1};
         if (instr == 32'h0000_0000) begin
            nop_r <= nop_r + {{(DW-1){1'b0}}, 1'b1};
         end else begin
            nop_r <= nop_r;
         end
      end
   end

   // Word captured in CAP: register data, or a counter for the two trailing indices
   always_comb begin
      cap_word_s = odata;
      if (idx_r == 6'(NREG)) begin
         cap_word_s = cyc_r;
      end else if (idx_r == 6'(NREG + 1)) begin
         cap_word_s = nop_r;
      end else begin
         cap_word_s = odata;
      end
   end
`else
   assign cap_word_s = odata;
`endif

   // Next-state logic; abort outside IDLE overrides everything including a transfer
   always_comb begin
      next_s = state_r;
      if (kill_s) begin
         next_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    next_s = start ? ADDR : IDLE;
            ADDR:    next_s = (SETTLE > 0) ? WAIT : CAP;
            WAIT:    next_s = (cnt_r <= 4'd1) ? CAP : WAIT;
            CAP:     next_s = OUT;
            OUT: begin
               if (!xfer_s) begin
                  next_s = OUT;
               end else if (idx_r == LAST_IDX) begin
                  next_s = DONE;
               end else if (idx_r >= REG_LAST) begin
                  next_s = CAP;
               end else begin
                  next_s = ADDR;
               end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Datapath and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_r       <= 6'd0;
         cnt_r       <= 4'd0;
         raddr_r     <= 5'd0;
         out_data_r  <= '0;
         out_idx_r   <= 6'd0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         chksum_r    <= '0;
      end else begin
         out_valid_r <= (next_s == OUT);
         busy_r      <= (next_s != IDLE);
         done_r      <= (next_s == DONE);
         if (!kill_s) begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     idx_r    <= 6'd0;
                     chksum_r <= '0;
                  end
               end
               ADDR: begin
                  raddr_r <= idx_r[4:0];
                  cnt_r   <= 4'(SETTLE);
               end
               WAIT:    cnt_r <= cnt_r - 4'd1;
               CAP: begin
                  out_data_r <= cap_word_s;
                  out_idx_r  <= idx_r;
                  chksum_r   <= chksum_r ^ cap_word_s;
               end
               OUT: begin
                  if (xfer_s && (idx_r != LAST_IDX)) begin
                     idx_r <= idx_r + 6'd1;
                  end
               end
               default: cnt_r <= cnt_r;
            endcase
         end
      end
   end

   assign raddr     = raddr_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign chksum    = chksum_r;

endmodule

// File: tb/tb_dbg_reg_scanner.sv
// Directed self-checking bench for dbg_reg_scanner; build with DBG_SCAN_PERF_EN to cover the counter words.
module tb_dbg_reg_scanner;
   localparam int NREG = 32;
`ifdef DBG_SCAN_PERF_EN
   localparam int NW = NREG + 2;
`else
   localparam int NW = NREG;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [4:0]  raddr;
   logic [31:0] odata;
   logic [31:0] out_data;
   logic [5:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic [31:0] chksum;
`ifdef DBG_SCAN_PERF_EN
   logic [31:0] instr;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mode     = 0;
   logic [31:0] exp_nop  = 32'd0;
   logic [31:0] bench_cyc;
   bit          found;

   dbg_reg_scanner #(.NREG(NREG), .DW(32), .SETTLE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .raddr     (raddr),
      .odata     (odata),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .chksum    (chksum)
`ifdef DBG_SCAN_PERF_EN
      ,
      .instr     (instr)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input int m, input logic [5:0] i);
      if (m == 0) return 32'h1000_0000 + {26'd0, i};
      return {i[3:0], 4'hA, 2'b00, i, 8'h5C, ~{2'b00, i}};
   endfunction

   always_comb odata = model(mode, {1'b0, raddr});

   // Reference cycle count since reset release, for the cycle-count word
   always @(posedge clk or negedge rst) begin
      if (!rst) bench_cyc <= 32'd0;
      else      bench_cyc <= bench_cyc + 32'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_raddr"}, {27'd0, raddr}, 32'd0);
      chk({tag, "_out_data"}, out_data, 32'd0);
      chk({tag, "_out_idx"}, {26'd0, out_idx}, 32'd0);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_chksum"}, chksum, 32'd0);
   endtask

   // One scan: stall uses ready pattern 1-0-0-1, poke_at re-pulses start, abort_at cancels
   task automatic do_scan(input bit stall, input int poke_at, input int abort_at);
      int          exp_idx = 0;
      int          seen = -1;
      int          last = 0;
      int          nd = 0;
      bit          ab = 1'b0;
      bit          rdy;
      bit [3:0]    pat = 4'b1001;
      logic [31:0] exp_ck = 32'd0;
      logic [31:0] w_cur = 32'd0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("chksum_cleared", chksum, 32'd0);
      for (int c = 0; c < 800; c++) begin
         if (done) nd++;
         else if (nd > 0) break;
         rdy = stall ? pat[c % 4] : 1'b1;
         out_ready = rdy;
         start = 1'b0;
         if (out_valid) begin
            if (exp_idx != seen) begin
               if (exp_idx < NREG)       w_cur = model(mode, 6'(exp_idx));
               else if (exp_idx == NREG) w_cur = bench_cyc - 32'd1;
               else                      w_cur = exp_nop;
               exp_ck ^= w_cur;
               seen = exp_idx;
            end
            chk("out_idx", {26'd0, out_idx}, 32'(exp_idx));
            chk("out_data", out_data, w_cur);
            if (exp_idx == abort_at) begin
               abort = 1'b1;
               ab = 1'b1;
            end else if (rdy) begin
               if (!stall && exp_idx > 0 && exp_idx < NREG) chk("xfer_gap", 32'(c - last), 32'd4);
               last = c;
               if (exp_idx == poke_at) start = 1'b1;
               exp_idx++;
            end
         end
         @(negedge clk);
         if (ab) break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (ab) begin
         chk("abort_valid", {31'd0, out_valid}, 32'd0);
         chk("abort_busy", {31'd0, busy}, 32'd0);
         for (int k = 0; k < 3; k++) begin
            if (done) nd++;
            @(negedge clk);
         end
         chk("abort_no_done", 32'(nd), 32'd0);
         chk("abort_chksum", chksum, exp_ck);
      end else begin
         chk("word_count", 32'(exp_idx), 32'(NW));
         chk("done_pulses", 32'(nd), 32'd1);
         chk("busy_end", {31'd0, busy}, 32'd0);
         chk("valid_end", {31'd0, out_valid}, 32'd0);
         chk("chksum_end", chksum, exp_ck);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b0;
`ifdef DBG_SCAN_PERF_EN
      instr = 32'h0000_0013;
`endif
      #1;
      chk_zero_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      mode = 0;
      do_scan(1'b0, -1, -1);
`ifndef DBG_SCAN_PERF_EN
      chk("chksum_const", chksum, 32'h0000_0000);
`endif

      mode = 1;
      do_scan(1'b1, -1, -1);

      mode = 0;
      do_scan(1'b0, -1, 5);
      chk("chksum_partial_const", chksum, 32'h0000_0001);
      do_scan(1'b0, -1, -1);

      mode = 1;
      found = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (!out_valid && busy && raddr == 5'd10) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("wait_idx10_found", {31'd0, found}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk_zero_outputs("midscan_rst");
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b0;
      exp_nop = 32'd0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      do_scan(1'b0, -1, -1);

`ifdef DBG_SCAN_PERF_EN
      instr = 32'h0000_0000;
      repeat (7) @(negedge clk);
      instr = 32'h0000_0013;
      exp_nop = 32'd7;
`endif
      mode = 0;
      do_scan(1'b0, 3, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
